// File: rtl/eth_rx_fifo_pkg.sv
// Shared definitions for the RX frame queue: entry layout, FSM encoding and packing helper.
// The entry bit offsets are also used by the queue reader.
package eth_rx_fifo_pkg;

    localparam int DATA_W  = 512;
    localparam int KEEP_W  = 64;
    localparam int ENTRY_W = DATA_W + KEEP_W + 1;

    localparam int TDATA_LSB = 0;
    localparam int TKEEP_LSB = 512;
    localparam int TLAST_BIT = 576;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DROP  = 2'd2,
        ST_TRUNC = 2'd3
    } state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic              tlast,
        input logic [KEEP_W-1:0] tkeep,
        input logic [DATA_W-1:0] tdata
    );
        logic [ENTRY_W-1:0] e;
        e                         = '0;
        e[TLAST_BIT]              = tlast;
        e[TKEEP_LSB +: KEEP_W]    = tkeep;
        e[TDATA_LSB +: DATA_W]    = tdata;
        return e;
    endfunction

endpackage

// File: rtl/eth_rx_fifo_if.sv
// MAC RX stream plus frame-queue write port, as seen between the environment (master)
// and the queue writer (slave).
interface eth_rx_fifo_if #(
    parameter int FIFO_DEPTH = 512
);
    import eth_rx_fifo_pkg::*;

    localparam int WC_W = $clog2(FIFO_DEPTH) + 1;

    logic                si_tvalid;
    logic [DATA_W-1:0]   si_tdata;
    logic [KEEP_W-1:0]   si_tkeep;
    logic                si_tlast;
    logic                si_tuser;

    logic                frame_q_full;
    logic [WC_W-1:0]     frame_q_wr_count;
    logic                frame_q_write;
    logic [ENTRY_W-1:0]  frame_q_din;

    modport master (
        output si_tvalid, si_tdata, si_tkeep, si_tlast, si_tuser,
        output frame_q_full, frame_q_wr_count,
        input  frame_q_write, frame_q_din
    );

    modport slave (
        input  si_tvalid, si_tdata, si_tkeep, si_tlast, si_tuser,
        input  frame_q_full, frame_q_wr_count,
        output frame_q_write, frame_q_din
    );

endinterface

// File: rtl/eth_rx_stat_counter.sv
// Free-running statistics counter with increment enable; wraps modulo 2^CNT_W.
module eth_rx_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/eth_rx_fifo_write.sv
// RX frame queue writer: registers the MAC stream, admits whole frames only when the
// queue has room for a worst-case frame, and drops or truncates the rest.
//
// state | meaning
// IDLE  | between frames; next beat is a first beat and gets the admission check
// PASS  | admitted frame in progress, beats are written
// DROP  | refused frame in progress, beats discarded until tlast
// TRUNC | queue overflowed mid-frame; waiting to write the tlast-only terminator
module eth_rx_fifo_write
    import eth_rx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH      = 512,
    parameter int MAX_FRAME_BEATS = 150,
    parameter int COUNT_LAT       = 4,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    eth_rx_fifo_if.slave     bus,
    output logic [CNT_W-1:0] cnt_frames_ok,
    output logic [CNT_W-1:0] cnt_frames_err,
    output logic [CNT_W-1:0] cnt_frames_drop,
    output logic [CNT_W-1:0] cnt_frames_trunc
);

    localparam int WC_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_PASS  = ST_PASS;
    localparam logic [1:0] S_DROP  = ST_DROP;
    localparam logic [1:0] S_TRUNC = ST_TRUNC;

    localparam logic [WC_W-1:0] DEPTH_C     = WC_W'(FIFO_DEPTH);
    localparam logic [WC_W-1:0] ADMIT_MIN_C = WC_W'(MAX_FRAME_BEATS + COUNT_LAT);

    logic                r_tvalid;
    logic [DATA_W-1:0]   r_tdata;
    logic [KEEP_W-1:0]   r_tkeep;
    logic                r_tlast;
    logic                r_tuser;

    logic [1:0]          state, state_nxt;
    logic                last_seen, last_seen_nxt;
    logic                nf_active, nf_active_nxt;

    logic [WC_W-1:0]     wr_count;
    logic [WC_W-1:0]     free_entries;
    logic                admit;
    logic                full;

    logic                wr_beat;
    logic                wr_term;
    logic                inc_ok, inc_err, inc_drop, inc_trunc;
    logic                old_last, new_beat, nf_after;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else begin
            r_tvalid <= bus.si_tvalid;
            r_tdata  <= bus.si_tdata;
            r_tkeep  <= bus.si_tkeep;
            r_tlast  <= bus.si_tlast;
            r_tuser  <= bus.si_tuser;
        end
    end

    // occupancy never exceeds FIFO_DEPTH, so the subtraction cannot wrap
    assign wr_count     = bus.frame_q_wr_count;
    assign free_entries = DEPTH_C - wr_count;
    assign admit        = (free_entries >= ADMIT_MIN_C);
    assign full         = bus.frame_q_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last_seen <= 1'b0;
            nf_active <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_seen <= last_seen_nxt;
            nf_active <= nf_active_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        last_seen_nxt = last_seen;
        nf_active_nxt = nf_active;
        wr_beat       = 1'b0;
        wr_term       = 1'b0;
        inc_ok        = 1'b0;
        inc_err       = 1'b0;
        inc_drop      = 1'b0;
        inc_trunc     = 1'b0;
        old_last      = 1'b0;
        new_beat      = 1'b0;
        nf_after      = nf_active;

        case (state)
            S_IDLE: begin
                if (r_tvalid) begin
                    if (admit) begin
                        if (full) begin
                            state_nxt     = S_TRUNC;
                            last_seen_nxt = r_tlast;
                            nf_active_nxt = 1'b0;
                        end else begin
                            wr_beat = 1'b1;
                            if (r_tlast) begin
                                inc_ok  = 1'b1;
                                inc_err = r_tuser;
                            end else begin
                                state_nxt = S_PASS;
                            end
                        end
                    end else if (r_tlast) begin
                        inc_drop = 1'b1;
                    end else begin
                        state_nxt = S_DROP;
                    end
                end
            end

            S_PASS: begin
                if (r_tvalid) begin
                    if (full) begin
                        state_nxt     = S_TRUNC;
                        last_seen_nxt = r_tlast;
                        nf_active_nxt = 1'b0;
                    end else begin
                        wr_beat = 1'b1;
                        if (r_tlast) begin
                            inc_ok    = 1'b1;
                            inc_err   = r_tuser;
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end

            S_DROP: begin
                if (r_tvalid && r_tlast) begin
                    inc_drop  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end

            S_TRUNC: begin
                // once the cut frame's tlast is seen, any further beat belongs to a new frame
                old_last = r_tvalid && r_tlast && !last_seen;
                new_beat = r_tvalid && last_seen;
                if (new_beat) begin
                    if (r_tlast) begin
                        inc_drop = 1'b1;
                        nf_after = 1'b0;
                    end else begin
                        nf_after = 1'b1;
                    end
                end
                if (old_last) begin
                    last_seen_nxt = 1'b1;
                end
                nf_active_nxt = nf_after;

                if (!full && (last_seen || old_last)) begin
                    wr_term       = 1'b1;
                    inc_trunc     = 1'b1;
                    state_nxt     = nf_after ? S_DROP : S_IDLE;
                    last_seen_nxt = 1'b0;
                    nf_active_nxt = 1'b0;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.frame_q_write = wr_beat | wr_term;
    assign bus.frame_q_din   = wr_beat ? pack_entry(r_tlast, r_tkeep, r_tdata) :
                               wr_term ? pack_entry(1'b1, '0, '0) :
                                         '0;

    eth_rx_stat_counter #(.CNT_W(CNT_W)) u_cnt_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_ok),
        .count (cnt_frames_ok)
    );

    eth_rx_stat_counter #(.CNT_W(CNT_W)) u_cnt_err (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_err),
        .count (cnt_frames_err)
    );

    eth_rx_stat_counter #(.CNT_W(CNT_W)) u_cnt_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_drop),
        .count (cnt_frames_drop)
    );

    eth_rx_stat_counter #(.CNT_W(CNT_W)) u_cnt_trunc (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_trunc),
        .count (cnt_frames_trunc)
    );

endmodule

// File: tb/tb_eth_rx_fifo_write.sv
// Directed bench for eth_rx_fifo_write: stimulus pushes expected queue entries with their
// due cycle, a negedge monitor pops and compares every queue write.
module tb_eth_rx_fifo_write;
    import eth_rx_fifo_pkg::*;

    localparam int FIFO_DEPTH = 512;
    localparam int CNT_W      = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    logic [CNT_W-1:0] cnt_ok, cnt_err, cnt_drop, cnt_trunc;

    eth_rx_fifo_write #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_FRAME_BEATS (150),
        .COUNT_LAT       (4),
        .CNT_W           (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cnt_frames_ok    (cnt_ok),
        .cnt_frames_err   (cnt_err),
        .cnt_frames_drop  (cnt_drop),
        .cnt_frames_trunc (cnt_trunc)
    );

    typedef struct {
        int                 cyc;
        logic [ENTRY_W-1:0] din;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_ok = 0, exp_err = 0, exp_drop = 0, exp_trunc = 0;

    localparam logic [KEEP_W-1:0] KALL = {KEEP_W{1'b1}};

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every queue write must match the head of the scoreboard in value and cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write cyc=%0d: no write seen, required entry due at cyc %0d", cyc, e.cyc);
        end
        if (bus.frame_q_write) begin
            checks++;
            if (bus.frame_q_full) begin
                errors++;
                $display("FAIL write_while_full cyc=%0d: write=1 full=1, required write=0", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d: got din=%h, required no write", cyc, bus.frame_q_din);
            end else begin
                e = sb.pop_front();
                if (e.din !== bus.frame_q_din || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL write_entry cyc=%0d (due %0d): got %h required %h",
                             cyc, e.cyc, bus.frame_q_din, e.din);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] w);
        return {16{w}};
    endfunction

    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                        input logic l, input logic u, input logic f);
        @(posedge clk);
        #1;
        bus.si_tvalid    = v;
        bus.si_tdata     = d;
        bus.si_tkeep     = k;
        bus.si_tlast     = l;
        bus.si_tuser     = u;
        bus.frame_q_full = f;
    endtask

    // drive one beat; full applies to the beat already sitting in the DUT input stage
    task automatic beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l,
                        input logic u, input logic f, input bit expect_wr);
        exp_t e;
        step(1'b1, d, k, l, u, f);
        if (expect_wr) begin
            e.cyc = cyc + 1;
            e.din = {l, k, d};
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic f);
        step(1'b0, '0, '0, 1'b0, 1'b0, f);
    endtask

    task automatic push_term();
        exp_t e;
        e.cyc = cyc;
        e.din = {1'b1, {KEEP_W{1'b0}}, {DATA_W{1'b0}}};
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_cnts(input string tag);
        chk({tag, "_ok"},    cnt_ok,    CNT_W'(exp_ok));
        chk({tag, "_err"},   cnt_err,   CNT_W'(exp_err));
        chk({tag, "_drop"},  cnt_drop,  CNT_W'(exp_drop));
        chk({tag, "_trunc"}, cnt_trunc, CNT_W'(exp_trunc));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            idle(1'b0);
            n++;
        end
        repeat (2) idle(1'b0);
        chk({tag, "_pending_writes"}, CNT_W'(sb.size()), '0);
        sb.delete();
    endtask

    initial begin
        rst                  = 1'b1;
        bus.si_tvalid        = 1'b0;
        bus.si_tdata         = '0;
        bus.si_tkeep         = '0;
        bus.si_tlast         = 1'b0;
        bus.si_tuser         = 1'b0;
        bus.frame_q_full     = 1'b0;
        bus.frame_q_wr_count = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_write", CNT_W'(bus.frame_q_write), '0);
        chk("reset_din_nonzero", CNT_W'(bus.frame_q_din != '0), '0);
        check_cnts("reset");

        // 1: empty queue, 3-beat frame, partial last beat
        beat(pat(32'h1111_0001), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h1111_0002), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h1111_0003), 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_ok = 1;
        drain("t1");
        check_cnts("t1");

        // 2: free=153 refused; free=154 admitted; count=0 admitted
        bus.frame_q_wr_count = 10'(FIFO_DEPTH - 153);
        beat(pat(32'h2222_0001), KALL, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(pat(32'h2222_0002), KALL, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_drop = 1;
        drain("t2a");
        check_cnts("t2a");
        bus.frame_q_wr_count = 10'(FIFO_DEPTH - 154);
        beat(pat(32'h2222_0003), 64'h0000_0000_0000_00FF, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_ok = 2;
        drain("t2b");
        check_cnts("t2b");
        bus.frame_q_wr_count = '0;
        beat(pat(32'h2222_0004), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h2222_0005), 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_ok = 3;
        drain("t2c");
        check_cnts("t2c");

        // 3: four back-to-back single-beat frames, error on the second
        beat(pat(32'h3333_0001), KALL, 1'b1, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h3333_0002), KALL, 1'b1, 1'b1, 1'b0, 1'b1);
        beat(pat(32'h3333_0003), KALL, 1'b1, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h3333_0004), KALL, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_ok  = 7;
        exp_err = 1;
        drain("t3");
        check_cnts("t3");

        // 4: full while beat 2 is presented, held 3 cycles; terminator after input tlast
        beat(pat(32'h4444_0001), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h4444_0002), KALL, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(pat(32'h4444_0003), KALL, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(pat(32'h4444_0004), KALL, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(pat(32'h4444_0005), KALL, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        push_term();
        exp_trunc = 1;
        drain("t4");
        check_cnts("t4");

        // 6: tlast lost to overflow, new frame arrives before terminator; terminator still first
        beat(pat(32'h6666_0001), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h6666_0002), KALL, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        beat(pat(32'h6666_0003), KALL, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        push_term();
        exp_trunc = 2;
        exp_drop  = 2;
        drain("t6");
        check_cnts("t6");

        // 5: reset in the middle of an admitted frame
        beat(pat(32'h5555_0001), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h5555_0002), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h5555_0003), KALL, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        chk("t5_write_after_reset", CNT_W'(bus.frame_q_write), '0);
        exp_ok = 0; exp_err = 0; exp_drop = 0; exp_trunc = 0;
        check_cnts("t5_reset");
        beat(pat(32'h5555_0011), KALL, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(pat(32'h5555_0012), 64'h0000_0000_0000_000F, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_ok  = 1;
        exp_err = 1;
        drain("t5");
        check_cnts("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
